// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Reads a multiplexed seven-segment bus (segments plus a one-hot digit select).
// Each digit must hold steady for STABLE sampled strobes before it is accepted.
// Accepted digits collect in a shadow frame. Once every slot has been seen, the
// frame is copied to the outputs and frame_valid pulses for a single cycle.
module seg7_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [6:0]        seg_in,
    input  logic [NDIG-1:0]   dig_sel,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   digit_err,
    output logic              frame_valid
);

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    logic [6:0]        last_seg;
    logic [NDIG-1:0]   last_sel;
    logic [3:0]        cnt;
    logic [4*NDIG-1:0] shadow_val;
    logic [NDIG-1:0]   shadow_err;
    logic [NDIG-1:0]   seen;

    logic       sel_onehot;
    logic       same;
    logic [3:0] cnt_nxt;
    logic       accept;
    logic       commit;
    logic [3:0] dec_val;
    logic       dec_err;

    // Filter next-count, accept and commit conditions.
    // Accept fires when the count first reaches STABLE. A new differing
    // sample always counts as a first arrival, so STABLE=1 accepts it at once.
    always_comb begin
        sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIG'(1))) == '0);
        same       = (seg_in == last_seg) && (dig_sel == last_sel);
        cnt_nxt    = 4'd1;
        if (same) begin
            cnt_nxt = (cnt < STABLE_C) ? cnt + 4'd1 : cnt;
        end
        accept = sample_en && sel_onehot && (cnt_nxt == STABLE_C) &&
                 (!same || (cnt != STABLE_C));
        commit = &seen;
    end

    // Segment pattern to digit value. Any pattern other than 0-9 is flagged.
    always_comb begin
        dec_val = 4'hF;
        dec_err = 1'b0;
        case (seg_in)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
            default: begin
                dec_val = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    // Stability filter. A sample whose select is not one-hot is discarded
    // and restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_seg <= '0;
            last_sel <= '0;
            cnt      <= '0;
        end else if (sample_en) begin
            if (!sel_onehot) begin
                cnt      <= '0;
                last_sel <= '0;
            end else begin
                cnt      <= cnt_nxt;
                last_seg <= seg_in;
                last_sel <= dig_sel;
            end
        end
    end

    // Shadow frame and seen mask. On a commit edge the seen mask restarts,
    // keeping only the slot accepted on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_err <= '0;
            seen       <= '0;
        end else begin
            if (commit) begin
                seen <= accept ? dig_sel : '0;
            end else if (accept) begin
                seen <= seen | dig_sel;
            end
            if (accept) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (dig_sel[i]) begin
                        shadow_val[4*i +: 4] <= dec_val;
                        shadow_err[i]        <= dec_err;
                    end
                end
            end
        end
    end

    // Publish the completed frame. The outputs see the shadow as it was
    // before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= commit;
            if (commit) begin
                digits    <= shadow_val;
                digit_err <= shadow_err;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder.
// Stimulus tasks push the expected frames {digits, digit_err} into exp_q.
// A monitor pops and compares each time frame_valid is seen.
// A second instance with STABLE=1 covers a commit and an accept on the same edge.
module tb_seg7_scan_decoder;
  localparam int NDIG = 4;
  localparam int W    = 5 * NDIG;

  localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                         P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011,
                         P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111,
                         P9 = 7'b1111011, PB = 7'b0000000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sample_en = 1'b0;
  logic            sample_en1 = 1'b0;
  logic [6:0]      seg_in = '0;
  logic [NDIG-1:0] dig_sel = '0;
  logic [4*NDIG-1:0] digits, digits1;
  logic [NDIG-1:0]   digit_err, digit_err1;
  logic              frame_valid, frame_valid1;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q1[$];
  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE(3)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .seg_in(seg_in),
    .dig_sel(dig_sel), .digits(digits), .digit_err(digit_err),
    .frame_valid(frame_valid)
  );

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en1), .seg_in(seg_in),
    .dig_sel(dig_sel), .digits(digits1), .digit_err(digit_err1),
    .frame_valid(frame_valid1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic strobe(input logic [6:0] s, input logic [NDIG-1:0] sel, input int n, input bit which);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seg_in     = s;
      dig_sel    = sel;
      sample_en  = !which;
      sample_en1 = which;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_en  = 1'b0;
      sample_en1 = 1'b0;
    end
  endtask

  task automatic scan4(input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] c, input logic [6:0] d);
    strobe(a, 4'b0001, 3, 0);
    strobe(b, 4'b0010, 3, 0);
    strobe(c, 4'b0100, 3, 0);
    strobe(d, 4'b1000, 3, 0);
    idle(3);
  endtask

  // scoreboard monitors
  always @(posedge clk) begin
    logic [W-1:0] e;
    #2;
    if (frame_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_unexpected: got %h/%b expected no frame", digits, digit_err);
      end else begin
        e = exp_q.pop_front();
        if ({digits, digit_err} !== e) begin
          n_fail++;
          $display("FAIL frame: got %h/%b expected %h/%b", digits, digit_err,
                   e[W-1:NDIG], e[NDIG-1:0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [W-1:0] e;
    #2;
    if (frame_valid1) begin
      n_tests++;
      if (exp_q1.size() == 0) begin
        n_fail++;
        $display("FAIL frame1_unexpected: got %h/%b expected no frame", digits1, digit_err1);
      end else begin
        e = exp_q1.pop_front();
        if ({digits1, digit_err1} !== e) begin
          n_fail++;
          $display("FAIL frame1: got %h/%b expected %h/%b", digits1, digit_err1,
                   e[W-1:NDIG], e[NDIG-1:0]);
        end
      end
    end
  end

  initial begin
    // reset held while strobes toggle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sample_en = 1'b1;
      seg_in    = (i % 2 == 0) ? P1 : P2;
      dig_sel   = 4'(1 << (i % 4));
      @(posedge clk);
      #2;
      chk("rst_digits", 32'(digits), 32'h0);
      chk("rst_err", 32'(digit_err), 32'h0);
      chk("rst_fv", 32'(frame_valid), 32'h0);
    end
    @(negedge clk);
    sample_en = 1'b0;
    rst_n     = 1'b1;
    idle(4);
    chk("post_rst_digits", 32'(digits), 32'h0);

    // clean scan
    exp_q.push_back({16'h4321, 4'b0000});
    scan4(P1, P2, P3, P4);

    // glitch rejection on slot 0
    exp_q.push_back({16'h7651, 4'b0000});
    strobe(P0, 4'b0001, 2, 0);
    scan4(P1, P5, P6, P7);

    // illegal (blank) pattern on slot 2
    exp_q.push_back({16'h0F89, 4'b0100});
    scan4(P9, P8, PB, P0);

    // non-one-hot select: discarded, counter restarts, nothing written
    exp_q.push_back({16'h5436, 4'b0000});
    strobe(P2, 4'b0001, 2, 0);
    strobe(P2, 4'b0011, 1, 0);
    strobe(P2, 4'b0001, 2, 0);
    strobe(P8, 4'b0011, 3, 0);
    strobe(P3, 4'b0010, 3, 0);
    strobe(P4, 4'b0100, 3, 0);
    strobe(P5, 4'b1000, 3, 0);
    idle(3);
    strobe(P6, 4'b0001, 3, 0);
    idle(3);

    // commit/accept collision on the STABLE=1 instance
    exp_q1.push_back({16'h4321, 4'b0000});
    exp_q1.push_back({16'h6789, 4'b0000});
    strobe(P1, 4'b0001, 1, 1);
    strobe(P2, 4'b0010, 1, 1);
    strobe(P3, 4'b0100, 1, 1);
    strobe(P4, 4'b1000, 1, 1);
    strobe(P9, 4'b0001, 1, 1);
    strobe(P8, 4'b0010, 1, 1);
    strobe(P7, 4'b0100, 1, 1);
    strobe(P6, 4'b1000, 1, 1);
    idle(4);

    // asynchronous reset mid-scan drops the partial frame
    strobe(P1, 4'b0001, 3, 0);
    strobe(P2, 4'b0010, 3, 0);
    @(negedge clk);
    sample_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_digits", 32'(digits), 32'h0);
    chk("async_rst_fv", 32'(frame_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    strobe(P3, 4'b0100, 3, 0);
    strobe(P4, 4'b1000, 3, 0);
    idle(6);
    chk("post_midreset_digits", 32'(digits), 32'h0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("exp_q1_drained", 32'(exp_q1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
